// File: rtl/ram_block_sequencer.sv
// Sequences RAM_memory block reads and presents each block to the hash core via valid/ready.
// Optional stall counter output enabled by defining RAM_SEQ_STALL_CNT_EN.
module ram_block_sequencer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              ram_next,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_last,
  output logic [CNT_W-1:0]  blk_idx,
  output logic              busy,
  output logic              done
`ifdef RAM_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [CNT_W-1:0] remaining;
  logic             is_last;

  assign is_last  = (blk_idx == remaining - CNT_W'(1));
  assign blk_last = blk_valid && is_last;

  // ram_next, busy and done are registered alongside the state so they change only on state entry
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      remaining <= '0;
      ram_next  <= 1'b0;
      blk_data  <= '0;
      blk_valid <= 1'b0;
      blk_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_blocks != '0) begin
              remaining <= num_blocks;
              ram_next  <= 1'b1;
              state     <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          ram_next <= 1'b0;
          lat_cnt  <= 3'(RD_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            blk_data  <= ram_data;
            blk_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        PRESENT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_idx   <= blk_idx + CNT_W'(1);
            if (is_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ram_next <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          blk_idx <= '0;
          state   <= IDLE;
        end
        default: begin
          ram_next  <= 1'b0;
          blk_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_SEQ_STALL_CNT_EN
  // Counts backpressure cycles for the current job; value survives DONE until the next start
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (state == PRESENT && blk_valid && !blk_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_block_sequencer.sv
// Directed bench for ram_block_sequencer: RD_LAT=1 instance driven from a cycle table,
// RD_LAT=3 instance for the latency sweep, plus reset/abort sequences.
module tb_ram_block_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_L;
  logic         start0, start1, ready0, ready1;
  logic [4:0]   num0, num1;
  logic         next0, next1, valid0, valid1, last0, last1, busy0, busy1, done0, done1;
  logic [127:0] rdata0, rdata1, bdata0, bdata1;
  logic [4:0]   idx0, idx1;
`ifdef RAM_SEQ_STALL_CNT_EN
  logic [15:0]  stall0, stall1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [127:0] word(input logic [31:0] a);
    return {32'hC0DE0000 | a, ~a, a ^ 32'h5A5A5A5A, a};
  endfunction

  // RAM models: address advances on each sampled next; data shows up RD_LAT cycles after next
  logic [31:0] addr0 = '0;
  logic [31:0] addr1 = '0;
  logic [31:0] addr1_d1 = '0;
  logic [31:0] addr1_d2 = '0;
  always @(posedge clk) begin
    if (next0) addr0 <= addr0 + 32'd1;
    if (next1) addr1 <= addr1 + 32'd1;
    addr1_d1 <= addr1;
    addr1_d2 <= addr1_d1;
  end
  assign rdata0 = word(addr0);
  assign rdata1 = word(addr1_d2);

  ram_block_sequencer #(.DATA_W(128), .CNT_W(5), .RD_LAT(1)) u0 (
    .clk(clk), .reset_L(reset_L), .start(start0), .num_blocks(num0),
    .ram_next(next0), .ram_data(rdata0), .blk_data(bdata0), .blk_valid(valid0),
    .blk_ready(ready0), .blk_last(last0), .blk_idx(idx0), .busy(busy0), .done(done0)
`ifdef RAM_SEQ_STALL_CNT_EN
    , .stall_cycles(stall0)
`endif
  );

  ram_block_sequencer #(.DATA_W(128), .CNT_W(5), .RD_LAT(3)) u1 (
    .clk(clk), .reset_L(reset_L), .start(start1), .num_blocks(num1),
    .ram_next(next1), .ram_data(rdata1), .blk_data(bdata1), .blk_valid(valid1),
    .blk_ready(ready1), .blk_last(last1), .blk_idx(idx1), .busy(busy1), .done(done1)
`ifdef RAM_SEQ_STALL_CNT_EN
    , .stall_cycles(stall1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic zero0(input string tag);
    chk({tag, " ram_next"},  int'(next0),  0);
    chk({tag, " blk_valid"}, int'(valid0), 0);
    chk({tag, " blk_last"},  int'(last0),  0);
    chk({tag, " blk_idx"},   int'(idx0),   0);
    chk({tag, " busy"},      int'(busy0),  0);
    chk({tag, " done"},      int'(done0),  0);
    chkw({tag, " blk_data"}, bdata0, '0);
  endtask

  typedef struct {
    int st; int n; int rd;
    int nx; int vl; int ls; int bs; int dn; int ix; int ad;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int st, input int n, input int rd, input int nx, input int vl,
                              input int ls, input int bs, input int dn, input int ix, input int ad);
    vec_t v;
    v.st = st; v.n = n; v.rd = rd; v.nx = nx; v.vl = vl;
    v.ls = ls; v.bs = bs; v.dn = dn; v.ix = ix; v.ad = ad;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nc[2];
    int vc[2];
    int lc[2];
    logic [127:0] vd[2];
    int n_nx;
    int n_vl;
    int dcyc;

    reset_L = 1'b1;
    start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    num0 = '0; num1 = '0;

    // columns: start num ready | ram_next valid last busy done idx data_addr(0 = not checked)
    // basic job, 3 blocks, extra starts in WAIT and DONE must be ignored
    vecs.push_back(mk(1,3,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 1,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 0,1,0,1,0,0,1));
    vecs.push_back(mk(0,0,1, 1,0,0,1,0,1,0));
    vecs.push_back(mk(1,7,1, 0,0,0,1,0,1,0));
    vecs.push_back(mk(0,0,1, 0,1,0,1,0,1,2));
    vecs.push_back(mk(0,0,1, 1,0,0,1,0,2,0));
    vecs.push_back(mk(0,0,1, 0,0,0,1,0,2,0));
    vecs.push_back(mk(0,0,1, 0,1,1,1,0,2,3));
    vecs.push_back(mk(1,2,1, 0,0,0,1,1,3,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0));
    // zero-length job
    vecs.push_back(mk(1,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,1,1,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0));
    // backpressure: 2 blocks, ready low for 5 cycles on block 0
    vecs.push_back(mk(1,2,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,1,0,0,0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,0, 0,1,0,1,0,0,4));
    vecs.push_back(mk(0,0,1, 0,1,0,1,0,0,4));
    vecs.push_back(mk(0,0,1, 1,0,0,1,0,1,0));
    vecs.push_back(mk(0,0,1, 0,0,0,1,0,1,0));
    vecs.push_back(mk(0,0,1, 0,1,1,1,0,1,5));
    vecs.push_back(mk(0,0,1, 0,0,0,1,1,2,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0));

    repeat (2) @(negedge clk);
    zero0("reset");
    chk("reset u1 busy", int'(busy1), 0);
    reset_L = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string r;
      r = $sformatf("row%0d", i);
      start0 = (vecs[i].st != 0);
      num0   = 5'(vecs[i].n);
      ready0 = (vecs[i].rd != 0);
      #1;
      chk({r, " ram_next"},  int'(next0),  vecs[i].nx);
      chk({r, " blk_valid"}, int'(valid0), vecs[i].vl);
      chk({r, " blk_last"},  int'(last0),  vecs[i].ls);
      chk({r, " busy"},      int'(busy0),  vecs[i].bs);
      chk({r, " done"},      int'(done0),  vecs[i].dn);
      chk({r, " blk_idx"},   int'(idx0),   vecs[i].ix);
      if (vecs[i].ad != 0) chkw({r, " blk_data"}, bdata0, word(32'(vecs[i].ad)));
      @(negedge clk);
    end
    start0 = 1'b0;
`ifdef RAM_SEQ_STALL_CNT_EN
    chk("stall_cycles after backpressure job", int'(stall0), 5);
`endif

    // asynchronous reset while a block is presented
    start0 = 1'b1; num0 = 5'd2; ready0 = 1'b0;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre-reset blk_valid", int'(valid0), 1);
    chkw("pre-reset blk_data", bdata0, word(32'd6));
    #1 reset_L = 1'b1;
    #1 zero0("async reset");
    @(negedge clk); reset_L = 1'b0; ready0 = 1'b1;

    // abort during WAIT of block 1 of 4, start while busy ignored
    start0 = 1'b1; num0 = 5'd4;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1; num0 = 5'd1;
    @(negedge clk); start0 = 1'b0; #1;
    chk("abort blk0 valid", int'(valid0), 1);
    chk("abort blk0 last", int'(last0), 0);
    chkw("abort blk0 data", bdata0, word(32'd7));
    @(negedge clk); #1;
    chk("abort fetch1 ram_next", int'(next0), 1);
    @(negedge clk); #1;
    chk("abort wait1 blk_idx", int'(idx0), 1);
    chk("abort wait1 busy", int'(busy0), 1);
    #1 reset_L = 1'b1;
    #1 zero0("abort reset");
    @(negedge clk); reset_L = 1'b0; start0 = 1'b1; num0 = 5'd1;
    @(negedge clk); start0 = 1'b0; #1;
    chk("reissue ram_next", int'(next0), 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("reissue valid", int'(valid0), 1);
    chk("reissue idx", int'(idx0), 0);
    chk("reissue last", int'(last0), 1);
    chkw("reissue data", bdata0, word(32'd9));
    @(negedge clk); #1;
    chk("reissue done", int'(done0), 1);
    chk("reissue ram_next in done", int'(next0), 0);
    @(negedge clk); #1;
    chk("reissue idle busy", int'(busy0), 0);
    chk("reissue idle idx", int'(idx0), 0);

    // latency sweep on the RD_LAT=3 instance
    nc = '{-1, -1}; vc = '{-1, -1}; lc = '{-1, -1}; vd = '{'0, '0};
    n_nx = 0; n_vl = 0; dcyc = -1;
    @(negedge clk); start1 = 1'b1; num1 = 5'd2; ready1 = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); start1 = 1'b0; #1;
      if (next1) begin
        if (n_nx < 2) nc[n_nx] = cyc;
        n_nx++;
      end
      if (valid1) begin
        if (n_vl < 2) begin
          vc[n_vl] = cyc; lc[n_vl] = int'(last1); vd[n_vl] = bdata1;
        end
        n_vl++;
      end
      if (done1 && dcyc < 0) dcyc = cyc;
    end
    chk("lat3 ram_next count", n_nx, 2);
    chk("lat3 ram_next cycle0", nc[0], 1);
    chk("lat3 ram_next cycle1", nc[1], 6);
    chk("lat3 valid count", n_vl, 2);
    chk("lat3 valid cycle0", vc[0], 5);
    chk("lat3 valid cycle1", vc[1], 10);
    chk("lat3 last0", lc[0], 0);
    chk("lat3 last1", lc[1], 1);
    chkw("lat3 data0", vd[0], word(32'd1));
    chkw("lat3 data1", vd[1], word(32'd2));
    chk("lat3 done cycle", dcyc, 11);
`ifdef RAM_SEQ_STALL_CNT_EN
    chk("lat3 stall_cycles", int'(stall1), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
